// File: rtl/axi_lite_stream_fifo_bridge.sv
`default_nettype none
// ============================================================================
// axi_lite_stream_fifo_bridge: AXI4-Lite register slave feeding a TX stream
// FIFO and draining an RX stream FIFO, with framing, flags and interrupt.
// Revision: 1.0
// ============================================================================
module axi_lite_stream_fifo_bridge #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int TDATA_WIDTH        = 32,
  parameter int TX_DEPTH           = 16,
  parameter int RX_DEPTH           = 16,
  parameter int TX_AFULL_THRESH    = 12
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [TDATA_WIDTH-1:0]          M_AXIS_TDATA,
  output logic                            M_AXIS_TLAST,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  input  logic [TDATA_WIDTH-1:0]          S_AXIS_TDATA,
  input  logic                            S_AXIS_TLAST,
  input  logic                            S_AXIS_TVALID,
  output logic                            S_AXIS_TREADY,
  output logic                            IRQ
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TPW = TAW + 1;
  localparam int RPW = RAW + 1;
  localparam int IW  = C_S_AXI_ADDR_WIDTH - 2;

  localparam logic [1:0]     RESP_OKAY   = 2'b00;
  localparam logic [1:0]     RESP_SLVERR = 2'b10;
  localparam logic [IW-1:0]  REG_TX_DATA = IW'(0);
  localparam logic [IW-1:0]  REG_RX_DATA = IW'(1);
  localparam logic [IW-1:0]  REG_STATUS  = IW'(2);
  localparam logic [IW-1:0]  REG_CONTROL = IW'(3);
  localparam logic [IW-1:0]  REG_TX_LAST = IW'(4);
  localparam logic [TPW-1:0] TX_FULL_COUNT = TPW'(TX_DEPTH);
  localparam logic [RPW-1:0] RX_FULL_COUNT = RPW'(RX_DEPTH);
  localparam logic [31:0]    AFULL_THRESH  = TX_AFULL_THRESH;

  // FIFO entries carry {tlast, tdata}
  logic [TDATA_WIDTH:0] tx_mem [TX_DEPTH];
  logic [TDATA_WIDTH:0] rx_mem [RX_DEPTH];
  logic [TPW-1:0]       tx_wr_ptr, tx_rd_ptr, tx_count;
  logic [RPW-1:0]       rx_wr_ptr, rx_rd_ptr, rx_count;
  logic [TDATA_WIDTH:0] tx_head, rx_head;
  logic                 tx_empty, tx_full, rx_empty, rx_full, tx_afull;

  logic                 aw_ready;
  logic                 stream_en;
  logic                 tx_ovf, rx_unf, irq_en;

  logic [IW-1:0]        wr_idx, rd_idx;
  logic                 wr_fire, rd_fire, ctrl_wr;
  logic                 tx_flush, rx_flush, clr_sticky;
  logic                 tx_push_req, tx_push, tx_pop, tx_ovf_now;
  logic                 rx_pop_req, rx_pop, rx_push, rx_unf_now;
  logic [31:0]          status;
  logic [C_S_AXI_DATA_WIDTH-1:0] rx_head_ext, rd_value;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WDATA};

  assign tx_count = tx_wr_ptr - tx_rd_ptr;
  assign rx_count = rx_wr_ptr - rx_rd_ptr;
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == TX_FULL_COUNT);
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == RX_FULL_COUNT);
  assign tx_afull = (32'(tx_count) >= AFULL_THRESH);
  assign tx_head  = tx_mem[tx_rd_ptr[TAW-1:0]];
  assign rx_head  = rx_mem[rx_rd_ptr[RAW-1:0]];

  assign M_AXIS_TDATA  = tx_head[TDATA_WIDTH-1:0];
  assign M_AXIS_TLAST  = tx_head[TDATA_WIDTH];
  assign M_AXIS_TVALID = !tx_empty;
  assign S_AXIS_TREADY = stream_en & !rx_full;
  assign S_AXI_AWREADY = aw_ready;
  assign S_AXI_WREADY  = aw_ready;

  assign wr_idx  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_fire = aw_ready & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire = S_AXI_ARREADY & S_AXI_ARVALID;

  assign ctrl_wr    = wr_fire & (wr_idx == REG_CONTROL);
  assign tx_flush   = ctrl_wr & S_AXI_WDATA[0];
  assign rx_flush   = ctrl_wr & S_AXI_WDATA[1];
  assign clr_sticky = ctrl_wr & S_AXI_WDATA[2];

  // Fullness is judged at the accept cycle, ignoring a same-cycle stream pop
  assign tx_push_req = wr_fire & ((wr_idx == REG_TX_DATA) | (wr_idx == REG_TX_LAST));
  assign tx_ovf_now  = tx_push_req & tx_full;
  assign tx_push     = tx_push_req & !tx_full & !tx_flush;
  assign tx_pop      = M_AXIS_TVALID & M_AXIS_TREADY & !tx_flush;

  assign rx_pop_req  = rd_fire & (rd_idx == REG_RX_DATA);
  assign rx_unf_now  = rx_pop_req & rx_empty & !rx_flush;
  assign rx_pop      = rx_pop_req & !rx_empty & !rx_flush;
  assign rx_push     = S_AXIS_TVALID & S_AXIS_TREADY & !rx_flush;

  always_comb begin
    rx_head_ext = '0;
    rx_head_ext[TDATA_WIDTH-1:0] = rx_head[TDATA_WIDTH-1:0];
    status        = '0;
    status[0]     = tx_empty;
    status[1]     = tx_full;
    status[2]     = rx_empty;
    status[3]     = rx_full;
    status[4]     = tx_ovf;
    status[5]     = rx_unf;
    status[6]     = tx_afull;
    status[7]     = !rx_empty & rx_head[TDATA_WIDTH];
    status[23:16] = 8'(tx_count);
    status[31:24] = 8'(rx_count);
    rd_value = '0;
    case (rd_idx)
      REG_RX_DATA: rd_value = rx_empty ? '0 : rx_head_ext;
      REG_STATUS:  rd_value = status;
      REG_CONTROL: rd_value[3] = irq_en;
      default:     rd_value = '0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (tx_push) tx_mem[tx_wr_ptr[TAW-1:0]] <= {wr_idx == REG_TX_LAST, S_AXI_WDATA[TDATA_WIDTH-1:0]};
    if (rx_push) rx_mem[rx_wr_ptr[RAW-1:0]] <= {S_AXIS_TLAST, S_AXIS_TDATA};
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_ready      <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RDATA   <= '0;
      stream_en     <= 1'b0;
      tx_wr_ptr     <= '0;
      tx_rd_ptr     <= '0;
      rx_wr_ptr     <= '0;
      rx_rd_ptr     <= '0;
      tx_ovf        <= 1'b0;
      rx_unf        <= 1'b0;
      irq_en        <= 1'b0;
      IRQ           <= 1'b0;
    end else begin
      stream_en <= 1'b1;

      aw_ready <= !aw_ready & S_AXI_AWVALID & S_AXI_WVALID & !S_AXI_BVALID;
      if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
      if (wr_fire) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= tx_ovf_now ? RESP_SLVERR : RESP_OKAY;
      end

      S_AXI_ARREADY <= !S_AXI_ARREADY & S_AXI_ARVALID & !S_AXI_RVALID;
      if (S_AXI_RVALID && S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
      if (rd_fire) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_value;
        S_AXI_RRESP  <= (rx_pop_req && rx_empty) ? RESP_SLVERR : RESP_OKAY;
      end

      if (tx_flush) begin
        tx_wr_ptr <= '0;
        tx_rd_ptr <= '0;
      end else begin
        if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
        if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      end

      if (rx_flush) begin
        rx_wr_ptr <= '0;
        rx_rd_ptr <= '0;
      end else begin
        if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
        if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      end

      // A fresh error in the clearing cycle keeps its flag set
      tx_ovf <= (tx_ovf & !clr_sticky) | tx_ovf_now;
      rx_unf <= (rx_unf & !clr_sticky) | rx_unf_now;
      if (ctrl_wr) irq_en <= S_AXI_WDATA[3];
      IRQ <= irq_en & (!rx_empty | tx_ovf | rx_unf);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_stream_fifo_bridge.sv
`default_nettype none
// ============================================================================
// tb_axi_lite_stream_fifo_bridge: randomized self-checking bench with a
// queue-based reference model of both FIFOs and the sticky flags.
// Revision: 1.0
// ============================================================================
module tb_axi_lite_stream_fifo_bridge;

  localparam int TX_DEPTH = 16;
  localparam int RX_DEPTH = 16;
  localparam int TX_AFULL = 12;
  localparam logic [4:0] A_TX_DATA = 5'h00, A_RX_DATA = 5'h04, A_STATUS = 5'h08,
                         A_CONTROL = 5'h0C, A_TX_LAST = 5'h10, A_UNMAPPED = 5'h1C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [31:0] m_tdata, s_tdata;
  logic        m_tlast, m_tvalid, m_tready, s_tlast, s_tvalid, s_tready, irq;

  int checks = 0;
  int errors = 0;

  logic [32:0] tx_q[$];
  logic [32:0] rx_q[$];
  logic [32:0] got_tx[$];
  logic        exp_ovf, exp_unf;

  always #5 clk = ~clk;

  axi_lite_stream_fifo_bridge #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .TDATA_WIDTH(32),
    .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .TX_AFULL_THRESH(TX_AFULL)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TLAST(m_tlast), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TLAST(s_tlast), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
    .IRQ(irq)
  );

  // Stream inputs only change just after a rising edge, so the falling edge
  // sees exactly what the next rising edge will handshake on.
  always @(negedge clk)
    if (rst_n && m_tvalid && m_tready) got_tx.push_back({m_tlast, m_tdata});

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    int txn = tx_q.size();
    int rxn = rx_q.size();
    s = '0;
    s[0] = (txn == 0);
    s[1] = (txn == TX_DEPTH);
    s[2] = (rxn == 0);
    s[3] = (rxn == RX_DEPTH);
    s[4] = exp_ovf;
    s[5] = exp_unf;
    s[6] = (txn >= TX_AFULL);
    s[7] = (rxn > 0) ? rx_q[0][32] : 1'b0;
    s[23:16] = 8'(txn);
    s[31:24] = 8'(rxn);
    return s;
  endfunction

  task automatic set_tready(input logic v);
    @(posedge clk); #1 m_tready = v;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL aw_timeout addr %h got awready 0 need 1", addr);
      awvalid = 1'b0; wvalid = 1'b0; resp = 2'bxx;
      return;
    end
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    resp = bresp;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL ar_timeout addr %h got arready 0 need 1", addr);
      arvalid = 1'b0; data = 'x; resp = 2'bxx;
      return;
    end
    @(posedge clk); #1 arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    data = rdata; resp = rresp;
  endtask

  task automatic send_rx(input logic [31:0] d, input logic l);
    int n = 0;
    @(posedge clk); #1 s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL rx_beat_timeout got tready 0 need 1");
    end
    @(posedge clk); #1 s_tvalid = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d; logic [1:0] r;
    repeat (2) @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b need 0", irq); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b need 0", m_tvalid); end
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_tready got %b need 1", s_tready); end
    axi_read(A_STATUS, d, r);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL reset_status got %h need 00000005", d); end
    axi_read(A_TX_DATA, d, r);
    checks++; if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL txdata_read got %h/%b need 0/00", d, r); end
    axi_read(A_UNMAPPED, d, r);
    checks++; if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL unmapped_read got %h/%b need 0/00", d, r); end
  endtask

  task automatic test_tx_basic;
    logic [1:0] r;
    logic [31:0] w [3];
    w[0] = 32'h0101FFFF; w[1] = 32'hABCD0001; w[2] = 32'hDEAD0011;
    got_tx.delete(); tx_q.delete();
    set_tready(1'b1);
    for (int i = 0; i < 3; i++) begin
      axi_write((i == 2) ? A_TX_LAST : A_TX_DATA, w[i], r);
      tx_q.push_back({i == 2, w[i]});
      checks++; if (r !== 2'b00) begin errors++; $display("FAIL basic_bresp%0d got %b need 00", i, r); end
    end
    repeat (6) @(posedge clk);
    checks++; if (got_tx.size() != 3) begin errors++; $display("FAIL basic_beats got %0d need 3", got_tx.size()); end
    for (int i = 0; i < 3 && i < got_tx.size(); i++) begin
      checks++;
      if (got_tx[i] !== tx_q[i]) begin errors++; $display("FAIL basic_beat%0d got %h need %h", i, got_tx[i], tx_q[i]); end
    end
    tx_q.delete();
  endtask

  task automatic test_tx_overflow;
    logic [1:0] r, er; logic [31:0] d;
    got_tx.delete();
    set_tready(1'b0);
    for (int i = 0; i < TX_DEPTH + 1; i++) begin
      d = $urandom;
      er = (tx_q.size() == TX_DEPTH) ? 2'b10 : 2'b00;
      if (tx_q.size() == TX_DEPTH) exp_ovf = 1'b1; else tx_q.push_back({1'b0, d});
      axi_write(A_TX_DATA, d, r);
      checks++; if (r !== er) begin errors++; $display("FAIL ovf_bresp%0d got %b need %b", i, r, er); end
    end
    axi_read(A_STATUS, d, r);
    checks++; if (d !== exp_status()) begin errors++; $display("FAIL ovf_status got %h need %h", d, exp_status()); end
    set_tready(1'b1);
    repeat (25) @(posedge clk);
    checks++; if (got_tx.size() != TX_DEPTH) begin errors++; $display("FAIL ovf_drain_count got %0d need %0d", got_tx.size(), TX_DEPTH); end
    for (int i = 0; i < TX_DEPTH && i < got_tx.size(); i++) begin
      checks++;
      if (got_tx[i] !== tx_q[i]) begin errors++; $display("FAIL ovf_beat%0d got %h need %h", i, got_tx[i], tx_q[i]); end
    end
    tx_q.delete();
  endtask

  task automatic test_rx;
    logic [1:0] r, er; logic [31:0] d, ed;
    axi_write(A_CONTROL, 32'h8, r);
    send_rx(32'hBEEF0011, 1'b1); rx_q.push_back({1'b1, 32'hBEEF0011});
    send_rx(32'h12345678, 1'b0); rx_q.push_back({1'b0, 32'h12345678});
    repeat (3) @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq got %b need 1", irq); end
    axi_read(A_STATUS, d, r);
    checks++; if (d !== exp_status()) begin errors++; $display("FAIL rx_status got %h need %h", d, exp_status()); end
    for (int i = 0; i < 3; i++) begin
      if (rx_q.size() > 0) begin ed = rx_q[0][31:0]; er = 2'b00; void'(rx_q.pop_front()); end
      else begin ed = 32'h0; er = 2'b10; exp_unf = 1'b1; end
      axi_read(A_RX_DATA, d, r);
      checks++;
      if (d !== ed || r !== er) begin errors++; $display("FAIL rx_read%0d got %h/%b need %h/%b", i, d, r, ed, er); end
    end
    axi_read(A_STATUS, d, r);
    checks++; if (d !== exp_status()) begin errors++; $display("FAIL rx_unf_status got %h need %h", d, exp_status()); end
  endtask

  task automatic test_rx_full;
    logic [1:0] r; logic [31:0] d, v; logic l;
    for (int i = 0; i < RX_DEPTH; i++) begin
      v = $urandom; l = 1'($urandom_range(0, 1));
      send_rx(v, l); rx_q.push_back({l, v});
    end
    @(negedge clk);
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rxfull_tready got %b need 0", s_tready); end
    axi_read(A_STATUS, d, r);
    checks++; if (d !== exp_status()) begin errors++; $display("FAIL rxfull_status got %h need %h", d, exp_status()); end
    while (rx_q.size() > 0) begin
      axi_read(A_RX_DATA, d, r);
      checks++;
      if (d !== rx_q[0][31:0] || r !== 2'b00) begin errors++; $display("FAIL rxfull_read got %h/%b need %h/00", d, r, rx_q[0][31:0]); end
      void'(rx_q.pop_front());
    end
  endtask

  task automatic test_sticky_flush;
    logic [1:0] r; logic [31:0] d, v;
    axi_write(A_CONTROL, 32'h4, r);
    exp_ovf = 1'b0; exp_unf = 1'b0;
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL clr_bresp got %b need 00", r); end
    axi_read(A_STATUS, d, r);
    checks++; if (d !== exp_status()) begin errors++; $display("FAIL clr_status got %h need %h", d, exp_status()); end
    repeat (2) @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clr_irq got %b need 0", irq); end
    got_tx.delete();
    set_tready(1'b0);
    for (int i = 0; i < 5; i++) begin v = $urandom; axi_write(A_TX_DATA, v, r); tx_q.push_back({1'b0, v}); end
    for (int i = 0; i < 3; i++) begin v = $urandom; send_rx(v, i[0]); rx_q.push_back({i[0], v}); end
    axi_read(A_STATUS, d, r);
    checks++; if (d !== exp_status()) begin errors++; $display("FAIL preflush_status got %h need %h", d, exp_status()); end
    axi_write(A_CONTROL, 32'h3, r);
    tx_q.delete(); rx_q.delete();
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL flush_tvalid got %b need 0", m_tvalid); end
    axi_read(A_STATUS, d, r);
    checks++; if (d !== exp_status()) begin errors++; $display("FAIL flush_status got %h need %h", d, exp_status()); end
    checks++; if (got_tx.size() != 0) begin errors++; $display("FAIL flush_leak got %0d beats need 0", got_tx.size()); end
  endtask

  task automatic test_random;
    logic [1:0] r, er; logic [31:0] d, ed, v; int op;
    got_tx.delete(); tx_q.delete();
    set_tready(1'b1);
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      v = $urandom;
      case (op)
        0, 1: begin
          axi_write(op == 1 ? A_TX_LAST : A_TX_DATA, v, r);
          tx_q.push_back({op == 1, v});
          checks++; if (r !== 2'b00) begin errors++; $display("FAIL rnd_bresp%0d got %b need 00", i, r); end
        end
        2: if (rx_q.size() < RX_DEPTH) begin send_rx(v, v[0]); rx_q.push_back({v[0], v}); end
        default: begin
          if (rx_q.size() > 0) begin ed = rx_q[0][31:0]; er = 2'b00; void'(rx_q.pop_front()); end
          else begin ed = 32'h0; er = 2'b10; exp_unf = 1'b1; end
          axi_read(A_RX_DATA, d, r);
          checks++;
          if (d !== ed || r !== er) begin errors++; $display("FAIL rnd_read%0d got %h/%b need %h/%b", i, d, r, ed, er); end
        end
      endcase
    end
    repeat (8) @(posedge clk);
    checks++; if (got_tx.size() != tx_q.size()) begin errors++; $display("FAIL rnd_tx_count got %0d need %0d", got_tx.size(), tx_q.size()); end
    for (int i = 0; i < tx_q.size() && i < got_tx.size(); i++) begin
      checks++;
      if (got_tx[i] !== tx_q[i]) begin errors++; $display("FAIL rnd_beat%0d got %h need %h", i, got_tx[i], tx_q[i]); end
    end
    tx_q.delete();
    axi_read(A_STATUS, d, r);
    checks++; if (d !== exp_status()) begin errors++; $display("FAIL rnd_status got %h need %h", d, exp_status()); end
  endtask

  task automatic test_reset_mid;
    logic [1:0] r; logic [31:0] d; int n;
    set_tready(1'b0);
    axi_write(A_TX_DATA, $urandom, r);
    axi_write(A_TX_DATA, $urandom, r);
    bready = 1'b0; rready = 1'b0;
    @(negedge clk); awaddr = A_TX_DATA; wdata = 32'h1; awvalid = 1'b1; wvalid = 1'b1;
    n = 0; while (!awready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk); araddr = A_STATUS; arvalid = 1'b1;
    n = 0; while (!arready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 arvalid = 1'b0;
    @(negedge clk);
    checks++; if ({bvalid, rvalid, m_tvalid} !== 3'b111) begin errors++; $display("FAIL pre_reset_valids got %b need 111", {bvalid, rvalid, m_tvalid}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bvalid, rvalid, m_tvalid} !== 3'b000) begin errors++; $display("FAIL reset_valids got %b need 000", {bvalid, rvalid, m_tvalid}); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL in_reset_tready got %b need 0", s_tready); end
    tx_q.delete(); rx_q.delete(); exp_ovf = 1'b0; exp_unf = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; bready = 1'b1; rready = 1'b1;
    repeat (2) @(posedge clk);
    axi_read(A_STATUS, d, r);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL post_reset_status got %h need 00000005", d); end
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = 4'hF;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    m_tready = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
    exp_ovf = 1'b0; exp_unf = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset;
    test_tx_basic;
    test_tx_overflow;
    test_rx;
    test_rx_full;
    test_sticky_flush;
    test_random;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
